ev_gen_scheduler: RTL and testbench

Generation sequencer for the EV3a evolutionary engine. It accepts a run configuration, counts the population load stream, then drives the shared evaluation/variation unit one individual at a time over a single-outstanding req/ack handshake. Phases run in the order evaluate → crossover → mutate for each generation. The block tracks the minimum fitness seen and reports it with a done pulse when the run finishes.

---
 rtl/ev_gen_scheduler.sv | 174 +++++++++++++++++
 tb/tb_ev_gen_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ev_gen_scheduler.sv
// Generation sequencer: load, then evaluate/crossover/mutate per generation, min-fitness tracking.
// Requests are registered, one in flight; unit_ack stalls the sequence with req/op/idx held.
module ev_gen_scheduler #(
    parameter int INT8_LENGTH    = 8,
    parameter int IND_FIT_LENGTH = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [INT8_LENGTH-1:0]    Num_generations,
    input  logic [INT8_LENGTH-1:0]    Pop_size,
    input  logic [INT8_LENGTH-1:0]    crossoverFraction,
    input  logic                      ind_valid,
    output logic                      unit_req,
    output logic [1:0]                unit_op,
    output logic [INT8_LENGTH-1:0]    unit_idx,
    input  logic                      unit_ack,
    input  logic [IND_FIT_LENGTH-1:0] unit_fit,
    output logic                      busy,
    output logic                      done,
    output logic [INT8_LENGTH-1:0]    gen_cnt,
    output logic [IND_FIT_LENGTH-1:0] best_fit,
    output logic [INT8_LENGTH-1:0]    best_idx,
    output logic [INT8_LENGTH-1:0]    best_gen
);

    localparam logic [1:0] OP_EVAL  = 2'b00;
    localparam logic [1:0] OP_XOVER = 2'b01;
    localparam logic [1:0] OP_MUT   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_EVAL, S_XOVER, S_MUTATE, S_GAP, S_DONE
    } state_t;

    state_t state, state_d;
    state_t nxt, nxt_d;

    logic [INT8_LENGTH-1:0]   p, g, x, load_cnt;
    logic [2*INT8_LENGTH-1:0] prod;
    logic                     req_d;
    logic [1:0]               op_d;
    logic [INT8_LENGTH-1:0]   idx_d;
    logic                     cfg_ok, fire, last_eval;

    assign prod   = {{INT8_LENGTH{1'b0}}, Pop_size} * {{INT8_LENGTH{1'b0}}, crossoverFraction};
    assign cfg_ok = (state == S_IDLE) && in_valid && (Pop_size != '0);
    assign fire   = unit_req && unit_ack;
    assign last_eval = (state == S_EVAL) && fire && (unit_idx == p - 1'b1);

    assign busy = (state != S_IDLE) && (state != S_DONE);
    assign done = (state == S_DONE);

    always_comb begin
        state_d = state;
        nxt_d   = nxt;
        req_d   = unit_req;
        op_d    = unit_op;
        idx_d   = unit_idx;
        case (state)
            S_IDLE: begin
                if (cfg_ok) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (ind_valid && (load_cnt == p - 1'b1)) begin
                    state_d = S_GAP;
                    nxt_d   = S_EVAL;
                end
            end
            S_EVAL: begin
                if (fire) begin
                    if (unit_idx == p - 1'b1) begin
                        req_d = 1'b0;
                        if (gen_cnt + 1'b1 == g) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_GAP;
                            if (x != '0)    nxt_d = S_XOVER;
                            else if (x < p) nxt_d = S_MUTATE;
                            else            nxt_d = S_EVAL;
                        end
                    end else begin
                        idx_d = unit_idx + 1'b1;
                    end
                end
            end
            S_XOVER: begin
                if (fire) begin
                    if (unit_idx == x - 1'b1) begin
                        req_d   = 1'b0;
                        state_d = S_GAP;
                        nxt_d   = (x < p) ? S_MUTATE : S_EVAL;
                    end else begin
                        idx_d = unit_idx + 1'b1;
                    end
                end
            end
            S_MUTATE: begin
                if (fire) begin
                    if (unit_idx == p - 1'b1) begin
                        req_d   = 1'b0;
                        state_d = S_GAP;
                        nxt_d   = S_EVAL;
                    end else begin
                        idx_d = unit_idx + 1'b1;
                    end
                end
            end
            S_GAP: begin
                // Launch the queued phase; mutate starts just past the crossover range.
                state_d = nxt;
                req_d   = 1'b1;
                idx_d   = (nxt == S_MUTATE) ? x : '0;
                if (nxt == S_XOVER)       op_d = OP_XOVER;
                else if (nxt == S_MUTATE) op_d = OP_MUT;
                else                      op_d = OP_EVAL;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            nxt      <= S_EVAL;
            unit_req <= 1'b0;
            unit_op  <= OP_EVAL;
            unit_idx <= '0;
        end else begin
            state    <= state_d;
            nxt      <= nxt_d;
            unit_req <= req_d;
            unit_op  <= op_d;
            unit_idx <= idx_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p        <= '0;
            g        <= '0;
            x        <= '0;
            load_cnt <= '0;
            gen_cnt  <= '0;
            best_fit <= '1;
            best_idx <= '0;
            best_gen <= '0;
        end else begin
            if (cfg_ok) begin
                p        <= Pop_size;
                g        <= (Num_generations == '0) ? {{(INT8_LENGTH-1){1'b0}}, 1'b1} : Num_generations;
                x        <= prod[2*INT8_LENGTH-1:INT8_LENGTH];
                load_cnt <= '0;
                gen_cnt  <= '0;
                best_fit <= '1;
                best_idx <= '0;
                best_gen <= '0;
            end
            if (state == S_LOAD && ind_valid) load_cnt <= load_cnt + 1'b1;
            // Strict compare: ties keep the earliest individual.
            if (state == S_EVAL && fire && (unit_fit < best_fit)) begin
                best_fit <= unit_fit;
                best_idx <= unit_idx;
                best_gen <= gen_cnt;
            end
            if (last_eval) gen_cnt <= gen_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ev_gen_scheduler.sv
// Bench for ev_gen_scheduler: request-stream scoreboard plus per-scenario result checks.
module tb_ev_gen_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] Num_generations = '0;
    logic [7:0] Pop_size = '0;
    logic [7:0] crossoverFraction = '0;
    logic       ind_valid = 1'b0;
    logic       unit_req;
    logic [1:0] unit_op;
    logic [7:0] unit_idx;
    logic       unit_ack = 1'b0;
    logic [9:0] unit_fit = '0;
    logic       busy, done;
    logic [7:0] gen_cnt, best_idx, best_gen;
    logic [9:0] best_fit;

    ev_gen_scheduler #(.INT8_LENGTH(8), .IND_FIT_LENGTH(10)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .Num_generations(Num_generations), .Pop_size(Pop_size),
        .crossoverFraction(crossoverFraction), .ind_valid(ind_valid),
        .unit_req(unit_req), .unit_op(unit_op), .unit_idx(unit_idx),
        .unit_ack(unit_ack), .unit_fit(unit_fit), .busy(busy), .done(done),
        .gen_cnt(gen_cnt), .best_fit(best_fit), .best_idx(best_idx), .best_gen(best_gen)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [7:0] idx;
        logic [9:0] fit;
    } req_t;

    req_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   fit_mode = 2;
    logic ack_en = 1'b1;
    int   stall_idx = 0;
    int   stall_left = 0;
    int   act_cnt[4];
    int   exp_cnt[4];
    int   done_cnt = 0;
    logic [9:0] exp_bf;
    logic [7:0] exp_bi, exp_bg, exp_gen;

    always @(posedge clk) cyc++;

    // Unit model: checks each visible request against the scoreboard, then answers it.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (rst_n && unit_req) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_req: op=%0d idx=%0d, required no request", unit_op, unit_idx);
                unit_ack = ack_en;
                unit_fit = '0;
            end else begin
                if (unit_op !== sb[0].op || unit_idx !== sb[0].idx) begin
                    errors++;
                    $display("FAIL req_stream: op=%0d idx=%0d, required op=%0d idx=%0d",
                             unit_op, unit_idx, sb[0].op, sb[0].idx);
                end
                unit_fit = sb[0].fit;
                if (stall_left > 0 && unit_op == 2'b00 && unit_idx == 8'(stall_idx)) begin
                    unit_ack = 1'b0;
                    stall_left--;
                end else begin
                    unit_ack = ack_en;
                end
                if (unit_ack) begin
                    act_cnt[unit_op]++;
                    void'(sb.pop_front());
                end
            end
        end else begin
            unit_ack = ack_en;
            unit_fit = '0;
        end
    end

    function automatic logic [9:0] fit_of(int gen, int idx);
        logic [9:0] t0 [4];
        t0 = '{10'd7, 10'd3, 10'd9, 10'd3};
        case (fit_mode)
            0:       fit_of = t0[idx % 4];
            1:       fit_of = (gen == 2 && idx == 2) ? 10'd1 : 10'(300 - idx - gen);
            default: fit_of = 10'(200 + idx * 3 + gen * 7);
        endcase
    endfunction

    task automatic build_expected(input int ng, input int ps, input int cf);
        int   gg, xx;
        req_t e;
        gg = (ng == 0) ? 1 : ng;
        xx = (ps * cf) >> 8;
        exp_bf = 10'h3FF; exp_bi = '0; exp_bg = '0; exp_gen = 8'(gg);
        for (int k = 0; k < 4; k++) begin exp_cnt[k] = 0; act_cnt[k] = 0; end
        done_cnt = 0;
        for (int gen = 0; gen < gg; gen++) begin
            for (int i = 0; i < ps; i++) begin
                e.op = 2'd0; e.idx = 8'(i); e.fit = fit_of(gen, i);
                sb.push_back(e); exp_cnt[0]++;
                if (e.fit < exp_bf) begin exp_bf = e.fit; exp_bi = 8'(i); exp_bg = 8'(gen); end
            end
            if (gen < gg - 1) begin
                for (int i = 0; i < xx; i++) begin
                    e.op = 2'd1; e.idx = 8'(i); e.fit = '0; sb.push_back(e); exp_cnt[1]++;
                end
                for (int i = xx; i < ps; i++) begin
                    e.op = 2'd2; e.idx = 8'(i); e.fit = '0; sb.push_back(e); exp_cnt[2]++;
                end
            end
        end
    endtask

    // Drives config then the population beats; t0 is the cycle stamp of the accepting edge.
    task automatic start_run(input int ng, input int ps, input int cf, output int t0);
        build_expected(ng, ps, cf);
        @(negedge clk);
        Num_generations = 8'(ng); Pop_size = 8'(ps); crossoverFraction = 8'(cf); in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        t0 = cyc;
        for (int i = 0; i < ps; i++) begin
            ind_valid = 1'b1;
            @(negedge clk);
        end
        ind_valid = 1'b0;
    endtask

    task automatic wait_done(output logic ok, output int at);
        int n;
        ok = 1'b0; at = 0; n = 0;
        while (!ok && n < 1000) begin
            @(negedge clk);
            n++;
            if (done) begin ok = 1'b1; at = cyc; end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({unit_req, unit_op, unit_idx, busy, done, gen_cnt, best_fit, best_idx, best_gen} !==
            {1'b0, 2'b00, 8'd0, 1'b0, 1'b0, 8'd0, 10'h3FF, 8'd0, 8'd0}) begin
            errors++;
            $display("FAIL reset_state: req=%0d op=%0d idx=%0d busy=%0d done=%0d gen=%0d bf=%0d bi=%0d bg=%0d, required 0,0,0,0,0,0,1023,0,0",
                     unit_req, unit_op, unit_idx, busy, done, gen_cnt, best_fit, best_idx, best_gen);
        end
    endtask

    task automatic test_basic;
        int t0, at; logic ok;
        fit_mode = 0;
        start_run(1, 4, 0, t0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: %0d, required 1", busy); end
        wait_done(ok, at);
        checks++;
        if (!ok || at - t0 != 9) begin errors++; $display("FAIL basic_latency: ok=%0d cycles=%0d, required 9", ok, at - t0); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: %0d, required 0", busy); end
        checks++;
        if (best_fit !== exp_bf || best_idx !== exp_bi || best_gen !== exp_bg || gen_cnt !== exp_gen) begin
            errors++;
            $display("FAIL basic_best: fit=%0d idx=%0d gen=%0d cnt=%0d, required %0d %0d %0d %0d",
                     best_fit, best_idx, best_gen, gen_cnt, exp_bf, exp_bi, exp_bg, exp_gen);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || done_cnt != 1) begin errors++; $display("FAIL basic_done_pulse: done=%0d pulses=%0d, required 0 and 1", done, done_cnt); end
        checks++;
        if (sb.size() != 0 || act_cnt[0] != 4 || act_cnt[1] != 0 || act_cnt[2] != 0) begin
            errors++; $display("FAIL basic_counts: left=%0d ev=%0d xo=%0d mu=%0d, required 0 4 0 0", sb.size(), act_cnt[0], act_cnt[1], act_cnt[2]);
        end
    endtask

    task automatic test_generations;
        int t0, at; logic ok;
        fit_mode = 1;
        start_run(3, 4, 128, t0);
        wait_done(ok, at);
        checks++;
        if (!ok || at - t0 != 31) begin errors++; $display("FAIL gens_latency: ok=%0d cycles=%0d, required 31", ok, at - t0); end
        checks++;
        if (sb.size() != 0 || act_cnt[0] != 12 || act_cnt[1] != 4 || act_cnt[2] != 4) begin
            errors++; $display("FAIL gens_counts: left=%0d ev=%0d xo=%0d mu=%0d, required 0 12 4 4", sb.size(), act_cnt[0], act_cnt[1], act_cnt[2]);
        end
        checks++;
        if (best_fit !== 10'd1 || best_idx !== 8'd2 || best_gen !== 8'd2 || gen_cnt !== 8'd3) begin
            errors++; $display("FAIL gens_best: fit=%0d idx=%0d gen=%0d cnt=%0d, required 1 2 2 3", best_fit, best_idx, best_gen, gen_cnt);
        end
    endtask

    task automatic test_stall;
        int t0, at; logic ok;
        fit_mode = 2;
        stall_idx = 1; stall_left = 5;
        start_run(1, 3, 0, t0);
        wait_done(ok, at);
        checks++;
        if (!ok || at - t0 != 12) begin errors++; $display("FAIL stall_latency: ok=%0d cycles=%0d, required 12", ok, at - t0); end
        checks++;
        if (sb.size() != 0 || act_cnt[0] != 3 || gen_cnt !== 8'd1 || stall_left != 0) begin
            errors++; $display("FAIL stall_counts: left=%0d ev=%0d cnt=%0d stall=%0d, required 0 3 1 0", sb.size(), act_cnt[0], gen_cnt, stall_left);
        end
        // Stray acks with fitness 0 while idle.
        repeat (5) @(negedge clk);
        checks++;
        if (best_fit !== exp_bf || best_idx !== exp_bi || gen_cnt !== 8'd1 || busy !== 1'b0) begin
            errors++; $display("FAIL stall_stray_ack: fit=%0d idx=%0d cnt=%0d busy=%0d, required %0d %0d 1 0", best_fit, best_idx, gen_cnt, busy, exp_bf, exp_bi);
        end
    endtask

    task automatic test_x_zero;
        int t0, at; logic ok;
        fit_mode = 2;
        start_run(2, 1, 255, t0);
        wait_done(ok, at);
        checks++;
        if (!ok || at - t0 != 7) begin errors++; $display("FAIL xzero_latency: ok=%0d cycles=%0d, required 7", ok, at - t0); end
        checks++;
        if (sb.size() != 0 || act_cnt[0] != 2 || act_cnt[1] != 0 || act_cnt[2] != 1 || gen_cnt !== 8'd2) begin
            errors++; $display("FAIL xzero_counts: left=%0d ev=%0d xo=%0d mu=%0d cnt=%0d, required 0 2 0 1 2", sb.size(), act_cnt[0], act_cnt[1], act_cnt[2], gen_cnt);
        end
    endtask

    task automatic test_cfg_corners;
        int t0, at; logic ok;
        fit_mode = 2;
        @(negedge clk);
        Num_generations = 8'd3; Pop_size = 8'd0; crossoverFraction = 8'd100; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || unit_req !== 1'b0 || gen_cnt !== 8'd2) begin
            errors++; $display("FAIL cfg_pop_zero: busy=%0d req=%0d cnt=%0d, required 0 0 2", busy, unit_req, gen_cnt);
        end
        start_run(0, 2, 0, t0);
        // Config and stray beat while busy must both be dropped.
        Num_generations = 8'd4; Pop_size = 8'd5; crossoverFraction = 8'd200;
        in_valid = 1'b1; ind_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; ind_valid = 1'b0;
        wait_done(ok, at);
        checks++;
        if (!ok || at - t0 != 5) begin errors++; $display("FAIL cfg_latency: ok=%0d cycles=%0d, required 5", ok, at - t0); end
        checks++;
        if (sb.size() != 0 || act_cnt[0] != 2 || gen_cnt !== 8'd1 || best_fit !== exp_bf) begin
            errors++; $display("FAIL cfg_gens_zero: left=%0d ev=%0d cnt=%0d fit=%0d, required 0 2 1 %0d", sb.size(), act_cnt[0], gen_cnt, best_fit, exp_bf);
        end
    endtask

    task automatic test_reset_mid;
        int t0, at, n; logic ok;
        fit_mode = 2;
        start_run(2, 4, 128, t0);
        n = 0;
        while (!(unit_req && unit_op == 2'b01) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin errors++; $display("FAIL rst_reach_xover: timed out, required crossover request"); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({unit_req, unit_op, unit_idx, busy, done, gen_cnt, best_fit, best_idx, best_gen} !==
            {1'b0, 2'b00, 8'd0, 1'b0, 1'b0, 8'd0, 10'h3FF, 8'd0, 8'd0}) begin
            errors++;
            $display("FAIL rst_mid_state: req=%0d op=%0d idx=%0d busy=%0d gen=%0d bf=%0d, required 0 0 0 0 0 1023",
                     unit_req, unit_op, unit_idx, busy, gen_cnt, best_fit);
        end
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start_run(1, 2, 0, t0);
        wait_done(ok, at);
        checks++;
        if (!ok || sb.size() != 0 || act_cnt[0] != 2 || best_fit !== exp_bf || best_idx !== exp_bi || gen_cnt !== 8'd1) begin
            errors++; $display("FAIL rst_rerun: ok=%0d left=%0d ev=%0d fit=%0d idx=%0d cnt=%0d, required 1 0 2 %0d %0d 1",
                               ok, sb.size(), act_cnt[0], best_fit, best_idx, gen_cnt, exp_bf, exp_bi);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        test_reset;
        test_basic;
        test_generations;
        test_stall;
        test_x_zero;
        test_cfg_corners;
        test_reset_mid;
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
